fetch_ctrl: RTL and testbench
=============================

Name: fetch_ctrl

Overview:
Sequencing controller for the IF stage. Drives the PC load enable and PC mux select, and runs the request/response handshake to instruction memory. Produces the IF/ID valid and flush strobes. Handles downstream stalls, and branch/jump redirects from EX that arrive while a fetch is in flight, discarding the stale response.

Parameters:
RESET_DELAY, 1, number of idle cycles in BOOT after reset release before the first fetch (0 = fetch on the first clock after release)

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous, active-low reset
imem_resp  input  1  instruction memory response valid; instruction data is valid this cycle
stall_i  input  1  IF/ID cannot accept (hazard or downstream stall)
br_taken  input  1  EX-stage redirect strobe, single cycle
br_is_jalr  input  1  qualifies br_taken: 1 = JALR target (LSB cleared), 0 = branch/JAL
imem_read  output  1  instruction memory read request
load_pc  output  1  PC register load enable
pcmux_sel  output  pcmux::pcmux_sel_t  PC source select (pc_plus4 / alu_out / alu_mod2)
if_valid  output  1  the instruction presented to IF/ID is valid
flush_ifid  output  1  invalidate the IF/ID register this cycle

Behaviour:
- Memory protocol:
  - Memory samples the address on the first cycle of a request.
  - A request starts on any imem_read-high cycle where the previous cycle had imem_read low or had imem_resp high.
  - imem_read must stay high until imem_resp.
  - PC may change after the request starts.
- Reset (rst low, async), all outputs and state forced:
  - state=BOOT, boot counter=0.
  - imem_read=0, load_pc=0, pcmux_sel=pc_plus4, if_valid=0, flush_ifid=0.
- Priority within a cycle: reset > br_taken > imem_resp > stall_i.
- Redirect target select: pcmux_sel=alu_mod2 if br_is_jalr, else alu_out. Applies on every br_taken cycle.
- BOOT:
  - imem_read=0.
  - Counts RESET_DELAY cycles, then moves to REQ.
  - br_taken is ignored.
- REQ:
  - imem_read=1.
  - imem_resp and not br_taken and not stall_i: if_valid=1, load_pc=1, pcmux_sel=pc_plus4, stay in REQ. This gives back-to-back fetch at one instruction per response.
  - imem_resp and stall_i (no br_taken): if_valid=1, load_pc=0, go to HOLD.
  - br_taken with imem_resp in the same cycle: response discarded (if_valid=0), flush_ifid=1, load_pc=1 with target, stay in REQ (new request next cycle).
  - br_taken without imem_resp: flush_ifid=1, load_pc=1 with target, go to KILL.
  - stall_i with no imem_resp: no effect; the request stays outstanding.
- KILL (stale request outstanding):
  - imem_read=1, if_valid=0.
  - imem_resp: response discarded, go to REQ.
  - A further br_taken: load_pc=1 with the new target, flush_ifid=1, stay in KILL.
  - br_taken together with imem_resp: load the new target, go to REQ.
- HOLD (instruction held for a stalled IF/ID):
  - imem_read=0, if_valid=1, load_pc=0.
  - stall_i falls: load_pc=1, pcmux_sel=pc_plus4, go to REQ.
  - br_taken: if_valid=0, flush_ifid=1, load_pc=1 with target, go to REQ. Overrides stall_i.
- Output timing:
  - All outputs are combinational from state and current inputs; there is no registered output latency.
  - load_pc takes effect at the next rising edge.
  - pcmux_sel=pc_plus4 whenever load_pc=0.
- Invariants:
  - Never load_pc=1 in BOOT.
  - if_valid and flush_ifid are never both 1.
  - At most one outstanding request.

Optional Feature:
FETCH_PERF_CNT_EN — when defined, adds three 32-bit outputs, each reset to 0 and wrapping at 2^32:
- perf_fetch_cnt: increments on every cycle with if_valid=1 and load_pc=1 (instruction accepted).
- perf_kill_cnt: increments on every discarded imem_resp.
- perf_stall_cnt: increments on every cycle spent in HOLD.
When undefined, these ports and counters do not exist and behaviour is otherwise identical.

Test Plan:
- Reset release, RESET_DELAY=1, imem_resp tied high -> imem_read rises on cycle 2; load_pc/if_valid high every cycle after with pcmux_sel=pc_plus4; PC 0x0,0x4,0x8.
- Response after 3 cycles, stall_i high from the response cycle for 2 cycles -> if_valid held high for 3 cycles, imem_read=0 and load_pc=0 in HOLD; load_pc=1 on the first cycle stall_i=0.
- br_taken (br_is_jalr=0) 1 cycle into a 4-cycle request -> flush_ifid=1, load_pc=1, pcmux_sel=alu_out; KILL; stale response has if_valid=0; next request starts the following cycle.
- br_taken with br_is_jalr=1 coincident with imem_resp -> pcmux_sel=alu_mod2, if_valid=0, flush_ifid=1, stays in REQ.
- Two br_taken pulses 2 cycles apart while in KILL -> load_pc on both cycles, exactly one discarded response, fetch resumes once; with FETCH_PERF_CNT_EN, perf_kill_cnt=1.
- rst asserted in KILL mid-request -> all outputs go to 0/pc_plus4 immediately (async); after release, the BOOT delay is honoured again.

Source files
------------

// File: rtl/fetch_ctrl.sv
// IF-stage sequencing controller: PC load/select, imem request handshake, IF/ID valid/flush.
// Optional performance counters are enabled by defining FETCH_PERF_CNT_EN.

package pcmux;
  typedef enum logic [1:0] {
    pc_plus4 = 2'd0,
    alu_out  = 2'd1,
    alu_mod2 = 2'd2
  } pcmux_sel_t;
endpackage

// state | meaning
// BOOT  | post-reset idle, counting RESET_DELAY cycles, no fetch
// REQ   | request outstanding (or starting) for the current PC
// KILL  | stale request outstanding after a redirect, its response is dropped
// HOLD  | fetched instruction held while IF/ID is stalled, no request
module fetch_ctrl #(
  parameter int RESET_DELAY = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              imem_resp,
  input  logic              stall_i,
  input  logic              br_taken,
  input  logic              br_is_jalr,
  output logic              imem_read,
  output logic              load_pc,
  output pcmux::pcmux_sel_t pcmux_sel,
  output logic              if_valid,
  output logic              flush_ifid
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]       perf_fetch_cnt,
  output logic [31:0]       perf_kill_cnt,
  output logic [31:0]       perf_stall_cnt
`endif
);

  localparam logic [1:0] S_BOOT = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_KILL = 2'd2;
  localparam logic [1:0] S_HOLD = 2'd3;

  localparam int            CW      = (RESET_DELAY < 1) ? 1 : $clog2(RESET_DELAY + 1);
  localparam logic [CW-1:0] C_DELAY = CW'(RESET_DELAY);
  localparam logic [CW-1:0] C_ONE   = CW'(1);

  logic [1:0]        r_state;
  logic [1:0]        w_next_state;
  logic [CW-1:0]     r_boot_cnt;
  logic              w_boot_done;
  pcmux::pcmux_sel_t w_target;

  assign w_boot_done = (r_boot_cnt == C_DELAY);
  assign w_target    = br_is_jalr ? pcmux::alu_mod2 : pcmux::alu_out;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= S_BOOT;
      r_boot_cnt <= '0;
    end else begin
      r_state <= w_next_state;
      if (r_state == S_BOOT && !w_boot_done)
        r_boot_cnt <= r_boot_cnt + C_ONE;
    end
  end

  // Redirect wins over a same-cycle response; the response is then simply not presented.
  always_comb begin
    w_next_state = r_state;
    imem_read    = 1'b0;
    load_pc      = 1'b0;
    pcmux_sel    = pcmux::pc_plus4;
    if_valid     = 1'b0;
    flush_ifid   = 1'b0;
    case (r_state)
      S_BOOT: begin
        if (w_boot_done)
          w_next_state = S_REQ;
      end
      S_REQ: begin
        imem_read = 1'b1;
        if (br_taken) begin
          flush_ifid = 1'b1;
          load_pc    = 1'b1;
          pcmux_sel  = w_target;
          if (!imem_resp)
            w_next_state = S_KILL;
        end else if (imem_resp) begin
          if_valid = 1'b1;
          if (stall_i)
            w_next_state = S_HOLD;
          else
            load_pc = 1'b1;
        end
      end
      S_KILL: begin
        imem_read = 1'b1;
        if (br_taken) begin
          flush_ifid = 1'b1;
          load_pc    = 1'b1;
          pcmux_sel  = w_target;
        end
        if (imem_resp)
          w_next_state = S_REQ;
      end
      S_HOLD: begin
        if (br_taken) begin
          flush_ifid   = 1'b1;
          load_pc      = 1'b1;
          pcmux_sel    = w_target;
          w_next_state = S_REQ;
        end else begin
          if_valid = 1'b1;
          if (!stall_i) begin
            load_pc      = 1'b1;
            w_next_state = S_REQ;
          end
        end
      end
      default: w_next_state = S_BOOT;
    endcase
  end

`ifdef FETCH_PERF_CNT_EN
  logic w_discard;

  // A response seen while requesting but not presented is exactly a discarded one.
  assign w_discard = imem_resp && imem_read && !if_valid;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_fetch_cnt <= '0;
      perf_kill_cnt  <= '0;
      perf_stall_cnt <= '0;
    end else begin
      if (if_valid && load_pc)
        perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
      if (w_discard)
        perf_kill_cnt <= perf_kill_cnt + 32'd1;
      if (r_state == S_HOLD)
        perf_stall_cnt <= perf_stall_cnt + 32'd1;
    end
  end
`endif

  a_valid_flush_excl: assert property (@(posedge clk) disable iff (!rst)
    !(if_valid && flush_ifid));
  a_no_load_in_boot: assert property (@(posedge clk) disable iff (!rst)
    (r_state == S_BOOT) |-> !load_pc);
  a_idle_sel: assert property (@(posedge clk) disable iff (!rst)
    !load_pc |-> (pcmux_sel == pcmux::pc_plus4));

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl: PC/memory model with a scoreboard of expected fetch addresses.
module tb_fetch_ctrl;

  logic              clk;
  logic              rst;
  logic              imem_resp;
  logic              stall_i;
  logic              br_taken;
  logic              br_is_jalr;
  logic              imem_read;
  logic              load_pc;
  pcmux::pcmux_sel_t pcmux_sel;
  logic              if_valid;
  logic              flush_ifid;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0]       perf_fetch_cnt;
  logic [31:0]       perf_kill_cnt;
  logic [31:0]       perf_stall_cnt;
`endif

  fetch_ctrl #(.RESET_DELAY(1)) u_dut (
    .clk        (clk),
    .rst        (rst),
    .imem_resp  (imem_resp),
    .stall_i    (stall_i),
    .br_taken   (br_taken),
    .br_is_jalr (br_is_jalr),
    .imem_read  (imem_read),
    .load_pc    (load_pc),
    .pcmux_sel  (pcmux_sel),
    .if_valid   (if_valid),
    .flush_ifid (flush_ifid)
`ifdef FETCH_PERF_CNT_EN
    ,
    .perf_fetch_cnt (perf_fetch_cnt),
    .perf_kill_cnt  (perf_kill_cnt),
    .perf_stall_cnt (perf_stall_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_tests = 0;
  int          n_fail  = 0;
  int          n_discard = 0;
  logic [31:0] r_alu;
  logic [31:0] r_pc;
  logic        r_prev_read;
  logic        r_prev_resp;
  logic [31:0] cur_addr;
  logic [31:0] exp_q[$];

  // PC register and request-start tracking as seen by instruction memory.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pc        <= 32'h0;
      r_prev_read <= 1'b0;
      r_prev_resp <= 1'b0;
    end else begin
      r_prev_read <= imem_read;
      r_prev_resp <= imem_resp;
      if (load_pc) begin
        case (pcmux_sel)
          pcmux::pc_plus4: r_pc <= r_pc + 32'd4;
          pcmux::alu_out:  r_pc <= r_alu;
          pcmux::alu_mod2: r_pc <= r_alu & ~32'd1;
          default:         r_pc <= 32'hDEAD_BEEF;
        endcase
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic sb_sample();
    logic [31:0] e;
    if (imem_read && (!r_prev_read || r_prev_resp))
      cur_addr = r_pc;
    if (if_valid && imem_resp) begin
      if (exp_q.size() == 0) begin
        check("sb_underflow", cur_addr, 32'hFFFF_FFFF);
      end else begin
        e = exp_q.pop_front();
        check("fetch_pc", cur_addr, e);
      end
    end
    if (imem_resp && imem_read && !if_valid)
      n_discard++;
    check("valid_flush_excl", {31'd0, if_valid & flush_ifid}, 32'd0);
    if (!load_pc)
      check("idle_sel", 32'(pcmux_sel), 32'(pcmux::pc_plus4));
  endtask

  task automatic cyc(input logic r, input logic s, input logic b, input logic j);
    @(posedge clk);
    #1;
    imem_resp  = r;
    stall_i    = s;
    br_taken   = b;
    br_is_jalr = j;
    @(negedge clk);
    sb_sample();
  endtask

  task automatic chk_out(input string tag, input logic rd, input logic ld,
                         input logic [1:0] sel, input logic vl, input logic fl);
    check({tag, ".imem_read"},  {31'd0, imem_read},  {31'd0, rd});
    check({tag, ".load_pc"},    {31'd0, load_pc},    {31'd0, ld});
    check({tag, ".pcmux_sel"},  32'(pcmux_sel),      32'(sel));
    check({tag, ".if_valid"},   {31'd0, if_valid},   {31'd0, vl});
    check({tag, ".flush_ifid"}, {31'd0, flush_ifid}, {31'd0, fl});
  endtask

  int disc0;

  initial begin
    rst = 1'b0; imem_resp = 1'b0; stall_i = 1'b0; br_taken = 1'b0; br_is_jalr = 1'b0;
    r_alu = 32'h0; cur_addr = 32'h0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_out("reset", 1'b0, 1'b0, 2'd0, 1'b0, 1'b0);

    // Boot delay with responses tied high, then back-to-back fetch.
    @(posedge clk); #1; rst = 1'b1;
    exp_q.push_back(32'h0); exp_q.push_back(32'h4); exp_q.push_back(32'h8);
    cyc(1, 0, 0, 0); chk_out("boot_c1", 1'b0, 1'b0, 2'd0, 1'b0, 1'b0);
    cyc(1, 0, 0, 0); chk_out("b2b_c2", 1'b1, 1'b1, 2'd0, 1'b1, 1'b0);
    cyc(1, 0, 0, 0); chk_out("b2b_c3", 1'b1, 1'b1, 2'd0, 1'b1, 1'b0);
    cyc(1, 0, 0, 0); chk_out("b2b_c4", 1'b1, 1'b1, 2'd0, 1'b1, 1'b0);

    // Slow response followed by a 2-cycle stall.
    exp_q.push_back(32'hC);
    cyc(0, 0, 0, 0); chk_out("slow_w1", 1'b1, 1'b0, 2'd0, 1'b0, 1'b0);
    cyc(0, 1, 0, 0); chk_out("slow_w2", 1'b1, 1'b0, 2'd0, 1'b0, 1'b0);
    cyc(1, 1, 0, 0); chk_out("stall_resp", 1'b1, 1'b0, 2'd0, 1'b1, 1'b0);
    cyc(0, 1, 0, 0); chk_out("hold", 1'b0, 1'b0, 2'd0, 1'b1, 1'b0);
    cyc(0, 0, 0, 0); chk_out("hold_rel", 1'b0, 1'b1, 2'd0, 1'b1, 1'b0);

    // Branch into an in-flight request, stale response dropped.
    disc0 = n_discard;
    r_alu = 32'h100;
    exp_q.push_back(32'h100);
    cyc(0, 0, 0, 0); chk_out("br_req", 1'b1, 1'b0, 2'd0, 1'b0, 1'b0);
    cyc(0, 0, 1, 0); chk_out("br_take", 1'b1, 1'b1, 2'd1, 1'b0, 1'b1);
    cyc(0, 0, 0, 0); chk_out("kill_wait", 1'b1, 1'b0, 2'd0, 1'b0, 1'b0);
    cyc(1, 0, 0, 0); chk_out("kill_resp", 1'b1, 1'b0, 2'd0, 1'b0, 1'b0);
    cyc(0, 0, 0, 0); chk_out("br_newreq", 1'b1, 1'b0, 2'd0, 1'b0, 1'b0);
    check("br_newreq_start", {31'd0, !r_prev_read || r_prev_resp}, 32'd1);
    cyc(1, 0, 0, 0); chk_out("br_fetch", 1'b1, 1'b1, 2'd0, 1'b1, 1'b0);
    check("br_discards", n_discard - disc0, 32'd1);

    // JALR redirect coincident with a response.
    r_alu = 32'h201;
    exp_q.push_back(32'h200);
    cyc(0, 0, 0, 0);
    cyc(1, 0, 1, 1); chk_out("jalr_resp", 1'b1, 1'b1, 2'd2, 1'b0, 1'b1);
    cyc(1, 0, 0, 0); chk_out("jalr_fetch", 1'b1, 1'b1, 2'd0, 1'b1, 1'b0);

    // Two redirects while killing: one discarded response, fetch resumes at the last target.
    disc0 = n_discard;
    exp_q.push_back(32'h400);
    cyc(0, 0, 0, 0);
    r_alu = 32'h300;
    cyc(0, 0, 1, 0); chk_out("kk_br1", 1'b1, 1'b1, 2'd1, 1'b0, 1'b1);
    cyc(0, 0, 0, 0); chk_out("kk_wait", 1'b1, 1'b0, 2'd0, 1'b0, 1'b0);
    r_alu = 32'h400;
    cyc(0, 0, 1, 0); chk_out("kk_br2", 1'b1, 1'b1, 2'd1, 1'b0, 1'b1);
    cyc(1, 0, 0, 0); chk_out("kk_resp", 1'b1, 1'b0, 2'd0, 1'b0, 1'b0);
    cyc(1, 0, 0, 0); chk_out("kk_fetch", 1'b1, 1'b1, 2'd0, 1'b1, 1'b0);
    check("kk_discards", n_discard - disc0, 32'd1);
`ifdef FETCH_PERF_CNT_EN
    check("perf_kill", perf_kill_cnt, 32'd3);
    check("perf_fetch", perf_fetch_cnt, 32'd7);
    check("perf_stall", perf_stall_cnt, 32'd2);
`endif

    // Async reset in KILL, then boot delay again.
    r_alu = 32'h600;
    cyc(0, 0, 0, 0);
    cyc(0, 0, 1, 0); chk_out("rk_br", 1'b1, 1'b1, 2'd1, 1'b0, 1'b1);
    br_taken = 1'b0;
    #1; chk_out("rk_kill", 1'b1, 1'b0, 2'd0, 1'b0, 1'b0);
    #1; rst = 1'b0;
    #1; chk_out("rk_async", 1'b0, 1'b0, 2'd0, 1'b0, 1'b0);
    @(posedge clk); #1; rst = 1'b1;
    exp_q.push_back(32'h0);
    cyc(0, 0, 0, 0); chk_out("rk_boot", 1'b0, 1'b0, 2'd0, 1'b0, 1'b0);
    cyc(1, 0, 0, 0); chk_out("rk_fetch", 1'b1, 1'b1, 2'd0, 1'b1, 1'b0);

    // Redirect out of HOLD overrides the stall.
    r_alu = 32'h500;
    exp_q.push_back(32'h4); exp_q.push_back(32'h500);
    cyc(1, 1, 0, 0); chk_out("hb_resp", 1'b1, 1'b0, 2'd0, 1'b1, 1'b0);
    cyc(0, 1, 1, 0); chk_out("hb_br", 1'b0, 1'b1, 2'd1, 1'b0, 1'b1);
    cyc(1, 0, 0, 0); chk_out("hb_fetch", 1'b1, 1'b1, 2'd0, 1'b1, 1'b0);

    check("sb_empty", exp_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
